// File: rtl/encoder_8x3_seq_if.sv
// Request/code handshake bundle for the sequential 8-to-3 encoder.
// The master side issues requests and consumes codes; the slave side is the encoder.
interface encoder_8x3_seq_if;
  logic [7:0] d;
  logic       load;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic       last;
  logic       busy;
  logic       drop;
  logic       zero;

  modport master (output d, load, ready,
                  input  code, valid, last, busy, drop, zero);
  modport slave  (input  d, load, ready,
                  output code, valid, last, busy, drop, zero);
endinterface

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and streams the index of
// every set bit, one per valid/ready transfer, in fixed priority order.
module encoder_8x3_seq #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  encoder_8x3_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SEL, SEND} state_t;

  state_t     state, state_n;
  logic [7:0] pend, pend_n;
  logic [2:0] code_q, code_n;
  logic       valid_q, valid_n;
  logic       last_q, last_n;
  logic       drop_q, drop_n;
  logic       zero_q, zero_n;

  logic [2:0] sel_idx;
  logic [7:0] rest;

  // Later assignments win, so the scan direction sets the priority.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (PRIO_HIGH) begin
        if (v[i]) p = 3'(i);
      end else begin
        if (v[7-i]) p = 3'(7-i);
      end
    end
    return p;
  endfunction

  assign sel_idx = pick(pend);
  assign rest    = pend & ~(8'd1 << sel_idx);

  always_comb begin
    state_n = state;
    pend_n  = pend;
    code_n  = code_q;
    valid_n = valid_q;
    last_n  = last_q;
    drop_n  = 1'b0;
    zero_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          if (bus.d != 8'd0) begin
            pend_n  = bus.d;
            state_n = SEL;
          end else begin
            zero_n = 1'b1;
          end
        end
      end
      SEL: begin
        drop_n  = bus.load;
        code_n  = sel_idx;
        valid_n = 1'b1;
        last_n  = (rest == 8'd0);
        pend_n  = rest;
        state_n = SEND;
      end
      SEND: begin
        drop_n = bus.load;
        if (bus.ready) begin
          // Reload the next pick on the accepting edge so valid never bubbles.
          if (pend != 8'd0) begin
            code_n = sel_idx;
            last_n = (rest == 8'd0);
            pend_n = rest;
          end else begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= 8'd0;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pend    <= pend_n;
      code_q  <= code_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      drop_q  <= drop_n;
      zero_q  <= zero_n;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.last  = last_q;
  assign bus.busy  = (state != IDLE);
  assign bus.drop  = drop_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Bench for encoder_8x3_seq: both priority orders side by side, checked every
// cycle against an ordered-list reference of the expected code stream.
module tb_encoder_8x3_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_in = 8'd0;
  logic       load_in = 1'b0;
  logic       ready_in = 1'b0;

  always #5 clk = ~clk;

  encoder_8x3_seq_if bus_h ();
  encoder_8x3_seq_if bus_l ();

  assign bus_h.d = d_in;  assign bus_h.load = load_in;  assign bus_h.ready = ready_in;
  assign bus_l.d = d_in;  assign bus_l.load = load_in;  assign bus_l.ready = ready_in;

  encoder_8x3_seq #(.PRIO_HIGH(1'b1)) u_hi (.clk(clk), .rst_n(rst_n), .bus(bus_h));
  encoder_8x3_seq #(.PRIO_HIGH(1'b0)) u_lo (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  logic [2:0] code_o [2];
  logic       valid_o [2], last_o [2], busy_o [2], drop_o [2], zero_o [2];
  assign code_o[0]  = bus_h.code;   assign code_o[1]  = bus_l.code;
  assign valid_o[0] = bus_h.valid;  assign valid_o[1] = bus_l.valid;
  assign last_o[0]  = bus_h.last;   assign last_o[1]  = bus_l.last;
  assign busy_o[0]  = bus_h.busy;   assign busy_o[1]  = bus_l.busy;
  assign drop_o[0]  = bus_h.drop;   assign drop_o[1]  = bus_l.drop;
  assign zero_o[0]  = bus_h.zero;   assign zero_o[1]  = bus_l.zero;

  // Reference: the list of codes owed for the captured request, plus a cursor.
  logic [2:0] seq [2][8];
  int         head [2], cnt [2];
  bit         m_busy [2], m_valid [2], m_drop [2], m_zero [2];
  int         n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_valid[k] = 0; m_drop[k] = 0; m_zero[k] = 0;
      head[k] = 0; cnt[k] = 0;
    end
  endtask

  task automatic fill(input int k, input logic [7:0] v);
    int i;
    cnt[k] = 0; head[k] = 0;
    for (int j = 0; j < 8; j++) begin
      i = (k == 0) ? 7 - j : j;
      if (v[i]) begin
        seq[k][cnt[k]] = 3'(i);
        cnt[k]++;
      end
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      m_drop[k] = load_in && m_busy[k];
      m_zero[k] = load_in && !m_busy[k] && (d_in == 8'd0);
      if (!m_busy[k]) begin
        if (load_in && d_in != 8'd0) begin
          fill(k, d_in);
          m_busy[k] = 1; m_valid[k] = 0;
        end
      end else if (!m_valid[k]) begin
        m_valid[k] = 1;
      end else if (ready_in) begin
        head[k]++;
        if (head[k] == cnt[k]) begin
          m_busy[k] = 0; m_valid[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), valid_o[k], m_valid[k]);
      chk($sformatf("busy%0d", k),  busy_o[k],  m_busy[k]);
      chk($sformatf("drop%0d", k),  drop_o[k],  m_drop[k]);
      chk($sformatf("zero%0d", k),  zero_o[k],  m_zero[k]);
      chk($sformatf("last%0d", k),  last_o[k],
          m_valid[k] && (head[k] == cnt[k] - 1));
      if (m_valid[k]) chk($sformatf("code%0d", k), code_o[k], seq[k][head[k]]);
      if (!rst_n)     chk($sformatf("rcode%0d", k), code_o[k], 0);
    end
  endtask

  task automatic step(input logic [7:0] dv, input logic ld, input logic rdy);
    d_in = dv; load_in = ld; ready_in = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) step(8'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);

    // Single request
    step(8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);

    // Multi request, ready held high
    step(8'hA4, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);

    // Backpressure
    step(8'h18, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);

    // Load while busy is dropped; load of zero in IDLE flags zero
    step(8'h81, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Load on the final handshake edge is dropped, next edge is accepted
    step(8'h02, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h40, 1'b1, 1'b1);
    step(8'h40, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 5 == 0) ? 8'h00 : 8'($urandom),
           ($urandom % 4 == 0), ($urandom % 3 != 0));
    for (int i = 0; i < 12; i++) step(8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-sequence, between edges
    step(8'hA4, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hA4, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
